// File: rtl/unmix_groups_iter.sv
// unmix_groups_iter: iterative DIZY group (un)mixing for the decryption datapath.
// The state splits into 8 groups of G = SIZE_STATE/8 bits, with g7 as the MSB group.
// Each BUSY cycle applies one group permutation. A transaction with in_rounds = k
// takes k steps. Only one transaction is in flight at a time.
//
// Optional feature macro: DIZY_MIX_DIR_EN adds the in_fwd port, which selects the
// forward or inverse step for the whole transaction.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   input handshake; in_data/in_rounds are sampled on accept
//   in_fwd              (DIZY_MIX_DIR_EN only) 1 = forward step, 0 = inverse step
//   out_valid/out_ready output handshake; out_data is held until the next result

`ifndef SIZE_STATE
`define SIZE_STATE 64
`endif

module unmix_groups_iter #(
    parameter int unsigned SIZE_STATE = `SIZE_STATE,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIZE_STATE-1:0] in_data,
    input  logic [CNT_W-1:0]      in_rounds,
`ifdef DIZY_MIX_DIR_EN
    input  logic                  in_fwd,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIZE_STATE-1:0] out_data
);

    localparam int unsigned G = SIZE_STATE / 8;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [SIZE_STATE-1:0]   data, data_n;
    logic [SIZE_STATE-1:0]   out_data_n;
    logic [SIZE_STATE-1:0]   step_c;
    logic                    out_valid_n, in_ready_n;

    // Inverse group permutation (new <- old); g7 and g0 stay in place.
    function automatic logic [SIZE_STATE-1:0] inv_step(input logic [SIZE_STATE-1:0] s);
        logic [SIZE_STATE-1:0] r;
        r          = s;
        r[6*G +: G] = s[5*G +: G];
        r[5*G +: G] = s[3*G +: G];
        r[4*G +: G] = s[1*G +: G];
        r[3*G +: G] = s[6*G +: G];
        r[2*G +: G] = s[4*G +: G];
        r[1*G +: G] = s[2*G +: G];
        return r;
    endfunction

`ifdef DIZY_MIX_DIR_EN
    logic fwd, fwd_n;

    // Forward group permutation (new <- old); the inverse of inv_step.
    function automatic logic [SIZE_STATE-1:0] fwd_step(input logic [SIZE_STATE-1:0] s);
        logic [SIZE_STATE-1:0] r;
        r          = s;
        r[6*G +: G] = s[3*G +: G];
        r[5*G +: G] = s[6*G +: G];
        r[4*G +: G] = s[2*G +: G];
        r[3*G +: G] = s[5*G +: G];
        r[2*G +: G] = s[1*G +: G];
        r[1*G +: G] = s[4*G +: G];
        return r;
    endfunction

    assign step_c = fwd ? fwd_step(data) : inv_step(data);
`else
    assign step_c = inv_step(data);
`endif

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            data      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef DIZY_MIX_DIR_EN
            fwd       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            data      <= data_n;
            out_data  <= out_data_n;
            out_valid <= out_valid_n;
            in_ready  <= in_ready_n;
`ifdef DIZY_MIX_DIR_EN
            fwd       <= fwd_n;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        data_n     = data;
        out_data_n = out_data;
`ifdef DIZY_MIX_DIR_EN
        fwd_n      = fwd;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    data_n = in_data;
                    cnt_n  = in_rounds;
`ifdef DIZY_MIX_DIR_EN
                    fwd_n  = in_fwd;
`endif
                    if (in_rounds == '0) begin
                        state_n    = DONE;
                        out_data_n = in_data;
                    end else begin
                        state_n = BUSY;
                    end
                end
            end
            BUSY: begin
                data_n = step_c;
                cnt_n  = cnt - CNT_W'(1);
                // The step that empties the counter publishes the result.
                if (cnt == CNT_W'(1)) begin
                    state_n    = DONE;
                    out_data_n = step_c;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        out_valid_n = (state_n == DONE);
        in_ready_n  = (state_n == IDLE);
    end

endmodule
